cpu_exec_ctrl: RTL
==================

Name: cpu_exec_ctrl

Overview:
- Execution sequencer for the 8-bit, 21-bit-instruction CPU system. Replaces the raw push-button clock and manualLoad switch.
- Runs the CPU from the board clock through a single-cycle clock-enable, CPU_CE.
- Provides load (PC reset-injection), single-step, free-run at a divided rate, and an address breakpoint.
- Sits between board switches/keys and the system block. It observes the CPU program address (Addr) and drives the CE and load-injection select.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required before the synchronised step key is accepted.
- RUN_DIV, 24'd1000000: CLK cycles between CE pulses in RUN. Legal range is 2..2^24-1.
- CNT_W, 16: width of the executed-instruction counter.

Ports:
- CLK  in  1  system clock; every flop is rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- STEP_KEY  in  1  raw push-button, active-low (pressed = 0), asynchronous to CLK.
- RUN_SW  in  1  raw switch; 1 = free-run requested.
- LOAD_SW  in  1  raw switch; 1 = load/PC-reset requested.
- BP_EN  in  1  breakpoint enable; quasi-static.
- BP_ADDR  in  8  breakpoint program address.
- ADDR  in  8  current CPU program address (Addr).
- CPU_CE  out  1  one-cycle enable; the CPU executes one instruction per pulse.
- LOAD_INJECT  out  1  1 = CPU instruction port takes the load instruction instead of ROM.
- STATE  out  3  0 = IDLE, 1 = LOAD, 2 = RUN, 3 = HALT.
- HALTED  out  1  1 while in HALT.
- INSTR_CNT  out  CNT_W  count of CE pulses issued outside LOAD; saturating.

Behaviour:
- Reset (RESET_N = 0, asynchronous):
  - STATE = IDLE; CPU_CE, LOAD_INJECT and HALTED = 0; INSTR_CNT = 0.
  - Synchronisers are cleared to inactive values: key released, switches 0. The debounce counter and run divider are cleared to 0.
  - Reset deassertion is used synchronously. No CE pulse is issued in the first cycle after release.
- Input conditioning:
  - STEP_KEY, RUN_SW and LOAD_SW each pass through a 2-flop synchroniser.
  - Step key: the synchronised level must hold unchanged for DEBOUNCE_CYCLES cycles before the debounced level updates.
  - step_evt is a single-cycle pulse on the debounced 1->0 transition (press). A release generates nothing.
- Priority, evaluated every cycle: LOAD_SW (sync) = 1 forces LOAD from any state. It overrides RUN, HALT and a pending step_evt.
- LOAD state:
  - LOAD_INJECT = 1 throughout.
  - CPU_CE = 1 for exactly the first cycle in LOAD only; the CPU executes the jump-to-0 load word once.
  - INSTR_CNT is cleared to 0 on entry. step_evt is ignored.
  - LOAD_SW = 0 -> IDLE. LOAD_INJECT drops in the same cycle STATE leaves LOAD.
- IDLE state:
  - step_evt -> CPU_CE = 1 for one cycle; stay in IDLE; INSTR_CNT += 1.
  - RUN_SW = 1 -> RUN, with the run divider cleared.
- RUN state:
  - The divider counts 0..RUN_DIV-1. At terminal count a slot occurs.
  - Slot with BP_EN = 1 and ADDR == BP_ADDR -> HALT with no CE.
  - Slot otherwise -> CPU_CE = 1 and INSTR_CNT += 1.
  - RUN_SW = 0 -> IDLE immediately. A slot coinciding with this is dropped.
  - step_evt is ignored.
- HALT state:
  - HALTED = 1; the CE is held off.
  - step_evt -> one CE pulse that bypasses the breakpoint compare; INSTR_CNT += 1.
  - In the same cycle, go to RUN if RUN_SW = 1, with the divider cleared; otherwise go to IDLE.
  - RUN_SW = 0 with no step_evt -> IDLE with no CE.
- CE and counter rules:
  - CPU_CE is never high on two consecutive cycles outside the single-step path. In RUN the minimum spacing is RUN_DIV.
  - INSTR_CNT saturates at all-ones and does not wrap.
- Breakpoint compare uses ADDR as sampled in the slot cycle. ADDR is stable between CE pulses.
- Reset mid-operation aborts any state, including the LOAD CE cycle. The block returns to IDLE with all outputs at reset values.

Test Plan (DEBOUNCE_CYCLES = 4, RUN_DIV = 3 unless stated):
- Reset, then LOAD_SW = 1 for 10 cycles, then 0. Required: STATE = 1 after 2 sync cycles; CPU_CE = 1 on exactly 1 cycle; LOAD_INJECT = 1 for the whole LOAD interval; INSTR_CNT = 0; STATE = 0 after release.
- In IDLE, STEP_KEY glitches low for 2 cycles, then is held low for 8 cycles. Required: no CE for the glitch; exactly one CE for the hold, appearing 2 + 4 cycles after the press; INSTR_CNT = 1; the release produces nothing.
- RUN_SW = 1 for 30 cycles with BP_EN = 0, ADDR driven by a model PC. Required: CE pulses spaced exactly 3 cycles apart, 10 pulses ±1; INSTR_CNT matches the pulse count.
- RUN with BP_EN = 1, BP_ADDR = 5, model PC counting from 0. Required: HALT entered at the slot where ADDR = 5, with no CE there; HALTED = 1. A step press then gives one CE, PC moves to 6, STATE = 2 and HALTED = 0.
- In RUN, assert LOAD_SW together with a step press. Required: LOAD wins, with a single load CE and INSTR_CNT = 0. Then with CNT_W = 4, issue 20 steps; required INSTR_CNT = 15 (saturated).
- RESET_N pulsed low during the LOAD CE cycle and during HALT. Required: CPU_CE, LOAD_INJECT and HALTED = 0 and STATE = 0 immediately (asynchronously); no CE in the first cycle after release.

Source files
------------

// File: rtl/cpu_exec_ctrl_if.sv
// Board/system-facing signal bundle of the execution sequencer.
// master: switches, keys and CPU address side; slave: the sequencer itself.
interface cpu_exec_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             step_key;
  logic             run_sw;
  logic             load_sw;
  logic             bp_en;
  logic [7:0]       bp_addr;
  logic [7:0]       addr;
  logic             cpu_ce;
  logic             load_inject;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output step_key, run_sw, load_sw, bp_en, bp_addr, addr,
    input  cpu_ce, load_inject, state, halted, instr_cnt
  );

  modport slave (
    input  step_key, run_sw, load_sw, bp_en, bp_addr, addr,
    output cpu_ce, load_inject, state, halted, instr_cnt
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer: drives a one-cycle CPU clock-enable for load, single-step,
// divided free-run and address breakpoint, from debounced board controls.
module cpu_exec_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] RUN_DIV         = 24'd1000000,
  parameter int          CNT_W           = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  cpu_exec_ctrl_if.slave bus
);
  localparam logic [2:0]       ST_IDLE  = 3'd0;
  localparam logic [2:0]       ST_LOAD  = 3'd1;
  localparam logic [2:0]       ST_RUN   = 3'd2;
  localparam logic [2:0]       ST_HALT  = 3'd3;
  localparam logic [15:0]      DB_LAST  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [23:0]      DIV_LAST = RUN_DIV - 24'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       key_sync_r, run_sync_r, load_sync_r;
  logic             key_s, run_s, load_s;
  logic             key_db_r;
  logic [15:0]      db_cnt_r;
  logic             step_evt_s;
  logic [23:0]      div_r, div_nxt_s;
  logic [2:0]       state_r, state_nxt_s;
  logic             ce_r, ce_nxt_s;
  logic             inject_r, inject_nxt_s;
  logic             halted_r;
  logic             cnt_clr_s, cnt_inc_s;
  logic [CNT_W-1:0] cnt_r;
  logic             slot_s, bp_hit_s;

  assign key_s  = key_sync_r[1];
  assign run_s  = run_sync_r[1];
  assign load_s = load_sync_r[1];

  // Two-flop synchronisers; key idles released (1), switches idle off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_sync_r  <= 2'b11;
      run_sync_r  <= 2'b00;
      load_sync_r <= 2'b00;
    end else begin
      key_sync_r  <= {key_sync_r[0], bus.step_key};
      run_sync_r  <= {run_sync_r[0], bus.run_sw};
      load_sync_r <= {load_sync_r[0], bus.load_sw};
    end
  end

  // Debounce: the synchronised key must differ from the accepted level for a full window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_db_r <= 1'b1;
      db_cnt_r <= 16'd0;
    end else if (key_s == key_db_r) begin
      db_cnt_r <= 16'd0;
    end else if (db_cnt_r == DB_LAST) begin
      key_db_r <= key_s;
      db_cnt_r <= 16'd0;
    end else begin
      db_cnt_r <= db_cnt_r + 16'd1;
    end
  end

  // Press is the accepted 1->0 transition; release is deliberately silent.
  assign step_evt_s = !key_s && key_db_r && (db_cnt_r == DB_LAST);
  assign slot_s     = (div_r == DIV_LAST);
  assign bp_hit_s   = bus.bp_en && (bus.addr == bus.bp_addr);
  assign cnt_inc_s  = ce_nxt_s && !load_s;

  // Next-state, CE and injection decisions; load switch has absolute priority.
  always_comb begin
    state_nxt_s  = state_r;
    ce_nxt_s     = 1'b0;
    inject_nxt_s = 1'b0;
    cnt_clr_s    = 1'b0;
    div_nxt_s    = div_r;
    if (load_s) begin
      state_nxt_s  = ST_LOAD;
      inject_nxt_s = 1'b1;
      ce_nxt_s     = (state_r != ST_LOAD);
      cnt_clr_s    = 1'b1;
      div_nxt_s    = 24'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          state_nxt_s = ST_IDLE;
          div_nxt_s   = 24'd0;
        end
        ST_IDLE: begin
          ce_nxt_s  = step_evt_s;
          div_nxt_s = 24'd0;
          if (run_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!run_s) begin
            state_nxt_s = ST_IDLE;
            div_nxt_s   = 24'd0;
          end else if (slot_s) begin
            div_nxt_s = 24'd0;
            if (bp_hit_s) begin
              state_nxt_s = ST_HALT;
            end else begin
              ce_nxt_s = 1'b1;
            end
          end else begin
            div_nxt_s = div_r + 24'd1;
          end
        end
        ST_HALT: begin
          div_nxt_s = 24'd0;
          if (step_evt_s) begin
            ce_nxt_s    = 1'b1;
            state_nxt_s = run_s ? ST_RUN : ST_IDLE;
          end else if (!run_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          div_nxt_s   = 24'd0;
        end
      endcase
    end
  end

  // State, divider and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      div_r    <= 24'd0;
      ce_r     <= 1'b0;
      inject_r <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      div_r    <= div_nxt_s;
      ce_r     <= ce_nxt_s;
      inject_r <= inject_nxt_s;
      halted_r <= (state_nxt_s == ST_HALT);
    end
  end

  // Saturating executed-instruction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.cpu_ce      = ce_r;
  assign bus.load_inject = inject_r;
  assign bus.state       = state_r;
  assign bus.halted      = halted_r;
  assign bus.instr_cnt   = cnt_r;
endmodule
